// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD request arbiter.
// Optional feature macro: SD_ARB_TIMEOUT_EN adds the TMO state and the
// ISSUE watchdog counter.
package sd_arb_pkg;

  // Width of a logical block address on the host interface.
  localparam int LBA_W = 32;

  // Default ISSUE watchdog in clk_sys cycles.
  localparam logic [23:0] TIMEOUT_DEF = 24'd12000000;

  // Arbiter states. TMO exists only when the watchdog is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3
`ifdef SD_ARB_TIMEOUT_EN
    ,
    ST_TMO   = 3'd4
`endif
  } arb_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Combinational round-robin picker: returns the first pending requester at
// or after rr_ptr, wrapping from NREQ-1 back to 0.
module sd_arb_rr
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (pending[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD host interface between NREQ virtual
// drives. A grant is issued only while sd_ack is low; the granted requester
// sees a read/write strobe until sd_ack rises, keeps its grant through the
// transfer, and gets a one-cycle done pulse after sd_ack falls.
// Optional feature macro: SD_ARB_TIMEOUT_EN -- a watchdog abandons an
// ISSUE that sees no sd_ack within TIMEOUT cycles and pulses err.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [LBA_W*NREQ-1:0] req_lba,
  input  logic                  sd_ack,
  output logic [LBA_W-1:0]      sd_lba,
  output logic [NREQ-1:0]       sd_rd,
  output logic [NREQ-1:0]       sd_wr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err
);

  localparam int IW = idx_w(NREQ);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    g_q, g_d;        // granted requester index
  logic             rd_q, rd_d;      // latched direction, 1 = read
  logic [LBA_W-1:0] lba_q, lba_d;    // LBA captured at grant time
  logic [IW-1:0]    ptr_q, ptr_d;    // round-robin start point

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]      cnt_q, cnt_d;    // cycles spent in ISSUE
`else
  // Watchdog compiled out; keep the parameter referenced.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  logic [NREQ-1:0]  pending;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [NREQ-1:0]  g_oh;
  logic [IW-1:0]    ptr_next;

  assign pending = req_rd | req_wr;

  sd_arb_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .pending (pending),
    .rr_ptr  (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // One-hot form of the granted index, used by every per-requester output.
  always_comb begin
    g_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_oh[i] = (g_q == IW'(i));
    end
  end

  // Pointer moves just past the requester that finished; stays 0 for NREQ==1.
  assign ptr_next = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);

  assign sd_lba = lba_q;

  // Next-state and output decode; outputs derive from registered state only.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rd_d    = rd_q;
    lba_d   = lba_q;
    ptr_d   = ptr_q;
`ifdef SD_ARB_TIMEOUT_EN
    cnt_d   = '0;
`endif
    sd_rd   = '0;
    sd_wr   = '0;
    gnt     = '0;
    done    = '0;
    err     = '0;

    case (state_q)
      ST_IDLE: begin
        // A high sd_ack here is left over from an aborted transfer.
        if (pick_valid && !sd_ack) begin
          state_d = ST_ISSUE;
          g_d     = pick_idx;
          rd_d    = req_rd[pick_idx];
          lba_d   = req_lba[LBA_W*int'(pick_idx) +: LBA_W];
        end
      end

      ST_ISSUE: begin
        gnt   = g_oh;
        sd_rd = rd_q ? g_oh : '0;
        sd_wr = rd_q ? '0 : g_oh;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 24'd1;
`endif
        // Host acceptance wins over a same-cycle withdrawal.
        if (sd_ack) begin
          state_d = ST_XFER;
        end else if (!req_rd[g_q] && !req_wr[g_q]) begin
          state_d = ST_IDLE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT - 24'd1) begin
          state_d = ST_TMO;
        end
`endif
      end

      ST_XFER: begin
        gnt = g_oh;
        if (!sd_ack) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = g_oh;
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end

`ifdef SD_ARB_TIMEOUT_EN
      ST_TMO: begin
        err     = g_oh;
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rd_q    <= 1'b0;
      lba_q   <= '0;
      ptr_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rd_q    <= rd_d;
      lba_q   <= lba_d;
      ptr_q   <= ptr_d;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter (NREQ=2, watchdog not built).
module tb_sd_req_arbiter;

  localparam int NREQ = 2;

  logic            clk_sys;
  logic            reset;
  logic [1:0]      req_rd, req_wr;
  logic [63:0]     req_lba;
  logic            sd_ack;
  logic [31:0]     sd_lba;
  logic [1:0]      sd_rd, sd_wr, gnt, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(24'd100)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_rd  (req_rd),
    .req_wr  (req_wr),
    .req_lba (req_lba),
    .sd_ack  (sd_ack),
    .sd_lba  (sd_lba),
    .sd_rd   (sd_rd),
    .sd_wr   (sd_wr),
    .gnt     (gnt),
    .done    (done),
    .err     (err)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Reference rule: first pending index at or after ptr, wrapping.
  function automatic int pick(input logic [1:0] pend, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Advance until a strobe appears; bounded.
  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if ((sd_rd | sd_wr) != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba = '0; sd_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_tests++;
    if ({sd_rd, sd_wr, gnt, done, err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b exp 0", {sd_rd, sd_wr, gnt, done, err});
    end
    n_tests++;
    if (sd_lba !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lba: got %h exp 0", sd_lba);
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_single();
    bit held;
    req_lba = {32'h0, 32'h10};
    req_rd  = 2'b01;
    @(negedge clk_sys);
    n_tests++;
    if (sd_rd !== 2'b01 || gnt !== 2'b01 || sd_lba !== 32'h10) begin
      n_fail++;
      $display("FAIL single_issue: got rd=%b gnt=%b lba=%h exp rd=01 gnt=01 lba=10", sd_rd, gnt, sd_lba);
    end
    held = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      if (sd_rd !== 2'b01) held = 1'b0;
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL single_hold: got strobe dropped exp sd_rd=01 held");
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    n_tests++;
    if (sd_rd !== 2'b00 || gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ackrise: got rd=%b gnt=%b exp rd=00 gnt=01", sd_rd, gnt);
    end
    req_rd = 2'b00;
    held = 1'b1;
    repeat (19) begin
      @(negedge clk_sys);
      if (gnt !== 2'b01 || done !== 2'b00 || sd_lba !== 32'h10) held = 1'b0;
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL single_xfer: got gnt/lba not held exp gnt=01 lba=10 done=00");
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (done !== 2'b01 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: got done=%b gnt=%b exp done=01 gnt=00", done, gnt);
    end
    @(negedge clk_sys);
    n_tests++;
    if (done !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done_len: got %b exp 00", done);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    int          exp_g   [3] = '{0, 1, 0};
    logic [31:0] exp_lba [3] = '{32'd1, 32'd2, 32'd1};
    pulse_reset();
    req_lba = {32'd2, 32'd1};
    req_rd  = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_strobe(ok);
      n_tests++;
      if (!ok || gnt !== (2'b01 << exp_g[t]) || sd_lba !== exp_lba[t]) begin
        n_fail++;
        $display("FAIL alt_grant%0d: got ok=%0d gnt=%b lba=%h exp gnt=%b lba=%h",
                 t, ok, gnt, sd_lba, 2'b01 << exp_g[t], exp_lba[t]);
      end
      sd_ack = 1'b1;
      @(negedge clk_sys);
      sd_ack = 1'b0;
      @(negedge clk_sys);
      n_tests++;
      if (done !== (2'b01 << exp_g[t])) begin
        n_fail++;
        $display("FAIL alt_done%0d: got %b exp %b", t, done, 2'b01 << exp_g[t]);
      end
      if (t == 2) req_rd = 2'b00;
    end
    @(negedge clk_sys);
  endtask

  task automatic test_both();
    bit ok;
    pulse_reset();
    req_lba = {32'hABCD, 32'h0};
    req_rd  = 2'b10;
    req_wr  = 2'b10;
    wait_strobe(ok);
    n_tests++;
    if (!ok || sd_rd !== 2'b10 || sd_wr !== 2'b00 || sd_lba !== 32'hABCD) begin
      n_fail++;
      $display("FAIL both_dir: got ok=%0d rd=%b wr=%b lba=%h exp rd=10 wr=00 lba=abcd", ok, sd_rd, sd_wr, sd_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    req_rd = 2'b00; req_wr = 2'b00; sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (done !== 2'b10) begin
      n_fail++;
      $display("FAIL both_done: got %b exp 10", done);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_drop();
    bit ok;
    pulse_reset();
    req_lba = {32'h200, 32'h100};
    req_rd  = 2'b11;
    wait_strobe(ok);
    n_tests++;
    if (!ok || gnt !== 2'b01 || sd_lba !== 32'h100) begin
      n_fail++;
      $display("FAIL drop_first: got ok=%0d gnt=%b lba=%h exp gnt=01 lba=100", ok, gnt, sd_lba);
    end
    req_rd = 2'b10;
    @(negedge clk_sys);
    n_tests++;
    if (sd_rd !== 2'b00 || gnt !== 2'b00 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_abort: got rd=%b gnt=%b done=%b exp all 00", sd_rd, gnt, done);
    end
    @(negedge clk_sys);
    n_tests++;
    if (sd_rd !== 2'b10 || sd_lba !== 32'h200) begin
      n_fail++;
      $display("FAIL drop_next: got rd=%b lba=%h exp rd=10 lba=200", sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    req_rd = 2'b00; sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (done !== 2'b10) begin
      n_fail++;
      $display("FAIL drop_done: got %b exp 10", done);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_reset_xfer();
    bit ok, quiet;
    req_lba = {32'h0, 32'h55};
    req_rd  = 2'b01;
    wait_strobe(ok);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    n_tests++;
    if (!ok || gnt !== 2'b01 || sd_rd !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_xfer: got ok=%0d gnt=%b rd=%b exp gnt=01 rd=00", ok, gnt, sd_rd);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    n_tests++;
    if ({sd_rd, sd_wr, gnt, done, err} !== 10'b0 || sd_lba !== 32'h0) begin
      n_fail++;
      $display("FAIL rx_reset: got outs=%b lba=%h exp 0", {sd_rd, sd_wr, gnt, done, err}, sd_lba);
    end
    reset = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk_sys);
      if (gnt !== 2'b00 || sd_rd !== 2'b00) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rx_stale_ack: got grant while ack high exp none");
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (sd_rd !== 2'b01 || sd_lba !== 32'h55) begin
      n_fail++;
      $display("FAIL rx_regrant: got rd=%b lba=%h exp rd=01 lba=55", sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    req_rd = 2'b00; sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL rx_done: got %b exp 01", done);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_random();
    bit          ok, eread;
    int          ptr, eg, d, xl;
    logic [1:0]  rr, ww, oh;
    logic [31:0] l0, l1, elba;
    pulse_reset();
    ptr = 0;
    for (int t = 0; t < 40; t++) begin
      do begin
        rr = 2'($urandom_range(0, 3));
        ww = 2'($urandom_range(0, 3));
      end while ((rr | ww) == 2'b00);
      l0 = $urandom; l1 = $urandom;
      req_rd = rr; req_wr = ww; req_lba = {l1, l0};
      eg    = pick(rr | ww, ptr);
      oh    = 2'b01 << eg;
      eread = rr[eg];
      elba  = (eg == 1) ? l1 : l0;
      wait_strobe(ok);
      n_tests++;
      if (!ok || gnt !== oh || sd_rd !== (eread ? oh : 2'b00) ||
          sd_wr !== (eread ? 2'b00 : oh) || sd_lba !== elba) begin
        n_fail++;
        $display("FAIL rand_grant%0d: got ok=%0d gnt=%b rd=%b wr=%b lba=%h exp gnt=%b read=%0d lba=%h",
                 t, ok, gnt, sd_rd, sd_wr, sd_lba, oh, eread, elba);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk_sys);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      n_tests++;
      if (gnt !== oh || (sd_rd | sd_wr) !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_xfer%0d: got gnt=%b rd=%b wr=%b exp gnt=%b no strobe", t, gnt, sd_rd, sd_wr, oh);
      end
      xl = $urandom_range(1, 4);
      repeat (xl) begin
        req_rd  = 2'($urandom_range(0, 3));
        req_wr  = 2'($urandom_range(0, 3));
        req_lba = {$urandom, $urandom};
        @(negedge clk_sys);
      end
      n_tests++;
      if (sd_lba !== elba || gnt !== oh) begin
        n_fail++;
        $display("FAIL rand_hold%0d: got lba=%h gnt=%b exp lba=%h gnt=%b", t, sd_lba, gnt, elba, oh);
      end
      sd_ack = 1'b0;
      @(negedge clk_sys);
      n_tests++;
      if (done !== oh || gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_done%0d: got done=%b gnt=%b exp done=%b gnt=00", t, done, gnt, oh);
      end
      ptr = (eg + 1) % NREQ;
    end
    req_rd = 2'b00; req_wr = 2'b00;
    @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba = '0; sd_ack = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_both();
    test_drop();
    test_reset_xfer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NREQ, 2, number of virtual-drive requesters (1..4, same range as VDNUM).
REQ-002 Parameter TIMEOUT, 24'd12000000, clk_sys cycles to wait for sd_ack rise (used only with SD_ARB_TIMEOUT_EN).
REQ-003 clk_sys  in  1  single system clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_rd  in  NREQ  per-requester sector read request, level.
REQ-006 req_wr  in  NREQ  per-requester sector write request, level.
REQ-007 req_lba  in  32*NREQ  packed LBAs; slice i = [32*i +: 32].
REQ-008 sd_ack  in  1  host transfer acknowledge.
REQ-009 sd_lba  out  32  LBA of granted requester.
REQ-010 sd_rd  out  NREQ  read strobe to host interface, at most one bit set.
REQ-011 sd_wr  out  NREQ  write strobe to host interface, at most one bit set.
REQ-012 gnt  out  NREQ  one-hot grant, set from issue until completion; muxes sector buffer.
REQ-013 done  out  NREQ  one-cycle completion pulse to granted requester.
REQ-014 err  out  NREQ  one-cycle timeout pulse (constant 0 without SD_ARB_TIMEOUT_EN).

Function
REQ-015 States: IDLE, ISSUE, XFER, DONE (plus TMO when SD_ARB_TIMEOUT_EN is defined).
REQ-016 IDLE: pending = req_rd|req_wr; when pending != 0 and sd_ack == 0, grant next pending index at or after rr_ptr (wrapping NREQ-1 -> 0), go to ISSUE next cycle.
REQ-017 IDLE with sd_ack == 1 (stale ack) SHALL not grant; stays IDLE.
REQ-018 Grant registers index g, latches req_lba[g] into sd_lba, and latches direction: read if req_rd[g], else write (read wins if both set).
REQ-019 ISSUE: sd_rd[g] or sd_wr[g] high, gnt[g] high; on sd_ack rise go to XFER and clear sd_rd/sd_wr same edge.
REQ-020 ISSUE: if requester drops both req_rd[g] and req_wr[g] before sd_ack rises, return to IDLE, no done, rr_ptr unchanged.
REQ-021 XFER: gnt[g] held, sd_lba held; requester changes ignored; on sd_ack fall go to DONE.
REQ-022 DONE: done[g] high exactly one cycle, gnt cleared, rr_ptr <= (g+1) mod NREQ, return to IDLE.
REQ-023 Grant-to-strobe latency 1 cycle; done pulse 1 cycle after sd_ack fall is sampled.
REQ-024 sd_lba SHALL change only on grant; other cycles hold last value.
REQ-025 NREQ == 1: rr_ptr constant 0, behaviour otherwise identical.

Reset
REQ-026 reset SHALL force state IDLE, rr_ptr 0, sd_rd/sd_wr/gnt/done/err 0, sd_lba 0, timeout counter 0, on the next edge, including mid-ISSUE or mid-XFER.
REQ-027 After reset during XFER, IDLE SHALL wait for sd_ack low before the next grant (per REQ-017).

Configuration
REQ-028 Macro SD_ARB_TIMEOUT_EN: when defined, a counter runs in ISSUE; reaching TIMEOUT without sd_ack rise goes to TMO, drops strobes, pulses err[g] one cycle, advances rr_ptr, returns to IDLE.
REQ-029 Without SD_ARB_TIMEOUT_EN: no counter, no TMO state, err tied 0, ISSUE waits indefinitely.

Structure
REQ-030 Package sd_arb_pkg SHALL hold the state enum, default TIMEOUT constant, and LBA width constant (32).
REQ-031 Sub-module sd_arb_rr SHALL implement the combinational round-robin picker (pending, rr_ptr -> valid, index).

Verification
REQ-032 NREQ=2, req_rd[0]=1, lba0=0x10; ack rises 5 cycles later, falls 20 later -> sd_rd=01 until ack rise, sd_lba=0x10, done=01 one cycle.
REQ-033 req_rd=11 held, lba0=1, lba1=2 -> grants alternate 0,1,0; sd_lba 1,2,1.
REQ-034 req_rd[1]=1 and req_wr[1]=1 -> sd_rd=10, sd_wr=00.
REQ-035 Requester 0 drops req in ISSUE before ack -> strobes clear next cycle, no done, then requester 1 pending is granted.
REQ-036 reset pulsed in XFER with sd_ack still 1 -> outputs 0; no new grant until ack falls.
REQ-037 With SD_ARB_TIMEOUT_EN, TIMEOUT=100, no ack -> err[g] pulses at cycle 100 of ISSUE, strobes dropped, next requester granted.
